reservation_station: RTL and testbench

//  One reservation station (RS) per math class; decode instantiates four, one per whichMath value.

---
 rtl/rs_pkg.sv | 61 ++++++
 rtl/rs_select.sv | 23 ++
 rtl/reservation_station.sv | 137 +++++++++++++
 tb/tb_reservation_station.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: types and constants shared by the reservation station and decode.
//   ROB_SIZE / TAG_W : ROB depth and tag width (tag 0 means "operand already valid")
//   CMD_W / VAL_W    : command width and operand width (bit 64 is carried but never issued)
//   CMD_*            : bit positions inside the 10-bit command word
//   rs_entry_t       : one station entry
//   wake_entry       : applies a completion broadcast to a valid entry's operands
package rs_pkg;

  localparam int ROB_SIZE = 8;

  function automatic int tag_width(input int rob_size);
    return $clog2(rob_size + 1);
  endfunction

  localparam int TAG_W = tag_width(ROB_SIZE);
  localparam int CMD_W = 10;
  localparam int VAL_W = 65;
  localparam int OUT_W = 64;

  // cmd = {read_en, saveCond, lshift, fwd, regWrite, ALUOp[2:0], memToReg, memWrite}
  localparam int CMD_READ_EN   = 9;
  localparam int CMD_SAVE_COND = 8;
  localparam int CMD_LSHIFT    = 7;
  localparam int CMD_FWD       = 6;
  localparam int CMD_REG_WRITE = 5;
  localparam int CMD_ALUOP_HI  = 4;
  localparam int CMD_ALUOP_LO  = 2;
  localparam int CMD_MEM_TO_REG = 1;
  localparam int CMD_MEM_WRITE = 0;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] dest_tag;
    logic [TAG_W-1:0] tag1;
    logic [VAL_W-1:0] val1;
    logic [TAG_W-1:0] tag2;
    logic [VAL_W-1:0] val2;
    logic [CMD_W-1:0] cmd;
  } rs_entry_t;

  // A zero broadcast tag never matches: tag 0 is reserved for "no wait".
  function automatic rs_entry_t wake_entry(input rs_entry_t e,
                                           input logic cdb_valid,
                                           input logic [TAG_W-1:0] cdb_tag,
                                           input logic [VAL_W-1:0] cdb_val);
    rs_entry_t r;
    r = e;
    if (e.valid && cdb_valid && (cdb_tag != '0)) begin
      if (e.tag1 == cdb_tag) begin
        r.tag1 = '0;
        r.val1 = cdb_val;
      end
      if (e.tag2 == cdb_tag) begin
        r.tag2 = '0;
        r.val2 = cdb_val;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rs_select: combinational priority encoder picking the oldest ready entry.
//   ready : one bit per entry, index 0 = oldest
//   found : any entry ready
//   idx   : lowest index whose ready bit is set (0 when none)
module rs_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scanning from the top down lets the lowest ready index win.
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) idx = IDX_W'(i);
    end
    found = |ready;
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: buffers renamed ops for one math class, snoops the
// completion broadcast to wake waiting operands, and issues the oldest ready
// op through a registered valid/ready port.
//   clk_i / reset_i (async, active-low) / flush_i (sync squash)
//   writeEn_i, destTag_i, tag1_i, val1_i, tag2_i, val2_i, cmd_i : op from decode
//   stall_o        : station full, a write this cycle is dropped
//   cdbValid_i, cdbTag_i, cdbVal_i : completion broadcast
//   issueValid_o / issueReady_i    : issue handshake
//   issueDestTag_o, issueVal1_o, issueVal2_o, issueCmd_o : issued op
// ROBsize must equal rs_pkg::ROB_SIZE because the entry struct is fixed-width.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ROBsize = ROB_SIZE
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        writeEn_i,
  input  logic [tag_width(ROBsize)-1:0] destTag_i,
  input  logic [tag_width(ROBsize)-1:0] tag1_i,
  input  logic [tag_width(ROBsize)-1:0] tag2_i,
  input  logic [VAL_W-1:0]            val1_i,
  input  logic [VAL_W-1:0]            val2_i,
  input  logic [CMD_W-1:0]            cmd_i,
  output logic                        stall_o,
  input  logic                        cdbValid_i,
  input  logic [tag_width(ROBsize)-1:0] cdbTag_i,
  input  logic [VAL_W-1:0]            cdbVal_i,
  output logic                        issueValid_o,
  input  logic                        issueReady_i,
  output logic [tag_width(ROBsize)-1:0] issueDestTag_o,
  output logic [OUT_W-1:0]            issueVal1_o,
  output logic [OUT_W-1:0]            issueVal2_o,
  output logic [CMD_W-1:0]            issueCmd_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t        ent [DEPTH];
  rs_entry_t        nxt [DEPTH];
  rs_entry_t        new_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] wr_slot;
  logic [DEPTH-1:0] ready;
  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic             fire;
  logic             write_acc;

  assign stall_o = (count == CNT_W'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = ent[i].valid && (ent[i].tag1 == '0) && (ent[i].tag2 == '0);
    end
  end

  rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .ready (ready),
    .found (found),
    .idx   (sel_idx)
  );

  assign fire      = (~issueValid_o | issueReady_i) & found & ~flush_i;
  assign write_acc = writeEn_i & ~stall_o & ~flush_i;
  // When issuing, the queue shifts first so the new op lands one slot lower.
  assign wr_slot   = fire ? (count - CNT_W'(1)) : count;

  always_comb begin
    new_entry.valid    = 1'b1;
    new_entry.dest_tag = destTag_i;
    new_entry.tag1     = tag1_i;
    new_entry.val1     = val1_i;
    new_entry.tag2     = tag2_i;
    new_entry.val2     = val2_i;
    new_entry.cmd      = cmd_i;
  end

  // Compaction, then wakeup on the shifted array so a captured value travels
  // with its entry, then the append of the incoming op (snooped as well).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) nxt[i] = ent[i];
    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) nxt[i] = ent[i+1];
      end
      nxt[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = wake_entry(nxt[i], cdbValid_i, cdbTag_i, cdbVal_i);
    end
    if (write_acc) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(wr_slot) == i) nxt[i] = wake_entry(new_entry, cdbValid_i, cdbTag_i, cdbVal_i);
      end
    end
  end

  always_comb begin
    count_n = count;
    if (write_acc && !fire) count_n = count + CNT_W'(1);
    else if (!write_acc && fire) count_n = count - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count          <= '0;
      issueValid_o   <= 1'b0;
      issueDestTag_o <= '0;
      issueVal1_o    <= '0;
      issueVal2_o    <= '0;
      issueCmd_o     <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count        <= '0;
      issueValid_o <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
      count <= count_n;
      if (fire) begin
        issueValid_o   <= 1'b1;
        issueDestTag_o <= ent[sel_idx].dest_tag;
        issueVal1_o    <= ent[sel_idx].val1[OUT_W-1:0];
        issueVal2_o    <= ent[sel_idx].val2[OUT_W-1:0];
        issueCmd_o     <= ent[sel_idx].cmd;
      end else if (issueReady_i) begin
        issueValid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: table-driven single-op vectors plus hand-written
// multi-cycle sequences; expected issues go into a scoreboard queue and are
// popped by a monitor whenever a handshake is seen.
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wr_en;
  logic [3:0]  dest_tag, tag1, tag2;
  logic [64:0] val1, val2;
  logic [9:0]  cmd;
  logic        stall;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [64:0] cdb_val;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_dest;
  logic [63:0] issue_v1, issue_v2;
  logic [9:0]  issue_cmd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  dest;
    logic [9:0]  cmd;
    logic [63:0] v1;
    logic [63:0] v2;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]  dest;
    logic [64:0] v1;
    logic [64:0] v2;
    logic [9:0]  cmd;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  reservation_station #(.DEPTH(4), .ROBsize(8)) dut (
    .clk_i          (clk),
    .reset_i        (rst_n),
    .flush_i        (flush),
    .writeEn_i      (wr_en),
    .destTag_i      (dest_tag),
    .tag1_i         (tag1),
    .tag2_i         (tag2),
    .val1_i         (val1),
    .val2_i         (val2),
    .cmd_i          (cmd),
    .stall_o        (stall),
    .cdbValid_i     (cdb_valid),
    .cdbTag_i       (cdb_tag),
    .cdbVal_i       (cdb_val),
    .issueValid_o   (issue_valid),
    .issueReady_i   (issue_ready),
    .issueDestTag_o (issue_dest),
    .issueVal1_o    (issue_v1),
    .issueVal2_o    (issue_v2),
    .issueCmd_o     (issue_cmd)
  );

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [9:0] c, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.dest = d; e.cmd = c; e.v1 = a; e.v2 = b;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [3:0] d, input logic [3:0] t1, input logic [64:0] v1,
                                input logic [3:0] t2, input logic [64:0] v2, input logic [9:0] c);
    dest_tag = d; tag1 = t1; val1 = v1; tag2 = t2; val2 = v2; cmd = c;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] t, input logic [64:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_val = v;
    tick();
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (sb.size() != 0 || issue_valid)) begin
      tick();
      i++;
    end
    n_checks++;
    if (sb.size() != 0 || issue_valid) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: pending %0d expected 0", sb.size());
    end
  endtask

  // Handshake is stable between edges, so sample at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_issue: got dest %0h expected none", issue_dest);
      end else begin
        e = sb.pop_front();
        check_output("issue_dest", 128'(issue_dest), 128'(e.dest));
        check_output("issue_val1", 128'(issue_v1), 128'(e.v1));
        check_output("issue_val2", 128'(issue_v2), 128'(e.v2));
        check_output("issue_cmd", 128'(issue_cmd), 128'(e.cmd));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{dest: 4'd3, v1: 65'd5, v2: 65'd7, cmd: 10'h155, e1: 64'd5, e2: 64'd7};
    vecs[1] = '{dest: 4'd1, v1: {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, v2: 65'd0, cmd: 10'h3FF,
                e1: 64'hFFFF_FFFF_FFFF_FFFF, e2: 64'd0};
    vecs[2] = '{dest: 4'd7, v1: 65'h0_8000_0000_0000_0001, v2: {1'b1, 64'd0}, cmd: 10'h000,
                e1: 64'h8000_0000_0000_0001, e2: 64'd0};
    vecs[3] = '{dest: 4'd8, v1: 65'h1234, v2: 65'hDEAD_BEEF, cmd: 10'h2AA,
                e1: 64'h1234, e2: 64'hDEAD_BEEF};

    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0;
    dest_tag = '0; tag1 = '0; tag2 = '0; val1 = '0; val2 = '0; cmd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; issue_ready = 1'b0;
    #1;
    check_output("reset_valid", 128'(issue_valid), 128'(0));
    check_output("reset_stall", 128'(stall), 128'(0));
    check_output("reset_dest", 128'(issue_dest), 128'(0));
    check_output("reset_val1", 128'(issue_v1), 128'(0));
    check_output("reset_cmd", 128'(issue_cmd), 128'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Ready ops: issue one cycle after the write, bit 64 dropped.
    $display("[TB] single ready ops");
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(vecs[i].dest, vecs[i].cmd, vecs[i].e1, vecs[i].e2);
      apply_stimulus(vecs[i].dest, 4'd0, vecs[i].v1, 4'd0, vecs[i].v2, vecs[i].cmd);
      check_output("latency_early", 128'(issue_valid), 128'(0));
      tick();
      check_output("latency_valid", 128'(issue_valid), 128'(1));
      tick();
      check_output("drained", 128'(issue_valid), 128'(0));
      check_output("stall_idle", 128'(stall), 128'(0));
    end

    // Wakeup of operand 1 from the broadcast.
    $display("[TB] wakeup");
    apply_stimulus(4'd4, 4'd2, 65'h99, 4'd0, 65'd9, 10'h011);
    for (int i = 0; i < 3; i++) begin
      check_output("wait_no_issue", 128'(issue_valid), 128'(0));
      tick();
    end
    push_exp(4'd4, 10'h011, 64'h2A, 64'd9);
    broadcast(4'd2, 65'h2A);
    check_output("wake_not_early", 128'(issue_valid), 128'(0));
    tick();
    check_output("wake_issue", 128'(issue_valid), 128'(1));
    check_output("wake_val1", 128'(issue_v1), 128'(64'h2A));
    wait_drain(10);

    // Full station with held issue register; sixth write dropped.
    $display("[TB] full and drop");
    issue_ready = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      push_exp(4'(d), 10'(d), 64'(d * 10), 64'(d));
      apply_stimulus(4'(d), 4'd0, 65'(d * 10), 4'd0, 65'(d), 10'(d));
    end
    check_output("full_stall", 128'(stall), 128'(1));
    check_output("full_hold_valid", 128'(issue_valid), 128'(1));
    check_output("full_hold_dest", 128'(issue_dest), 128'(1));
    apply_stimulus(4'd6, 4'd0, 65'd60, 4'd0, 65'd6, 10'd6);
    check_output("drop_stall", 128'(stall), 128'(1));
    check_output("drop_hold_val1", 128'(issue_v1), 128'(10));
    issue_ready = 1'b1;
    wait_drain(20);

    // Younger ready op overtakes an older waiting one.
    $display("[TB] ordering");
    push_exp(4'd6, 10'h006, 64'd66, 64'd6);
    apply_stimulus(4'd5, 4'd4, 65'd0, 4'd0, 65'd1, 10'h005);
    apply_stimulus(4'd6, 4'd0, 65'd66, 4'd0, 65'd6, 10'h006);
    tick(); tick(); tick();
    check_output("order_b_done", 128'(sb.size()), 128'(0));
    push_exp(4'd5, 10'h005, 64'h44, 64'd1);
    broadcast(4'd4, 65'h44);
    wait_drain(10);
    check_output("order_stall", 128'(stall), 128'(0));

    // Same-cycle write + issue at count 2, with the write snooping the broadcast.
    $display("[TB] write with issue");
    issue_ready = 1'b0;
    push_exp(4'd1, 10'd1, 64'h11, 64'd1);
    push_exp(4'd3, 10'd3, 64'h13, 64'd3);
    push_exp(4'd4, 10'd4, 64'h55, 64'd4);
    push_exp(4'd5, 10'd5, 64'h15, 64'd5);
    push_exp(4'd6, 10'd6, 64'h16, 64'd6);
    push_exp(4'd2, 10'd2, 64'h33, 64'd2);
    apply_stimulus(4'd1, 4'd0, 65'h11, 4'd0, 65'd1, 10'd1);
    apply_stimulus(4'd2, 4'd3, 65'h0, 4'd0, 65'd2, 10'd2);
    apply_stimulus(4'd3, 4'd0, 65'h13, 4'd0, 65'd3, 10'd3);
    issue_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 65'h55;
    apply_stimulus(4'd4, 4'd5, 65'hBAD, 4'd0, 65'd4, 10'd4);
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0;
    issue_ready = 1'b0;
    check_output("wi_issue_dest", 128'(issue_dest), 128'(3));
    check_output("wi_stall", 128'(stall), 128'(0));
    apply_stimulus(4'd5, 4'd0, 65'h15, 4'd0, 65'd5, 10'd5);
    check_output("wi_count3", 128'(stall), 128'(0));
    apply_stimulus(4'd6, 4'd0, 65'h16, 4'd0, 65'd6, 10'd6);
    check_output("wi_count4", 128'(stall), 128'(1));
    issue_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_output("wi_q_waiting", 128'(issue_valid), 128'(0));
    check_output("wi_only_q_left", 128'(sb.size()), 128'(1));
    broadcast(4'd3, 65'h33);
    wait_drain(10);

    // Flush with a held issue and three queued; a write in the flush cycle is lost.
    $display("[TB] flush");
    issue_ready = 1'b0;
    for (int d = 1; d <= 4; d++) apply_stimulus(4'(d), 4'd0, 65'(d), 4'd0, 65'(d), 10'(d));
    check_output("pre_flush_valid", 128'(issue_valid), 128'(1));
    flush = 1'b1;
    apply_stimulus(4'd9, 4'd0, 65'd9, 4'd0, 65'd9, 10'd9);
    flush = 1'b0;
    check_output("flush_valid", 128'(issue_valid), 128'(0));
    check_output("flush_stall", 128'(stall), 128'(0));
    issue_ready = 1'b1;
    tick(); tick(); tick();
    check_output("flush_empty", 128'(issue_valid), 128'(0));
    push_exp(4'd7, 10'h07, 64'd70, 64'd71);
    apply_stimulus(4'd7, 4'd0, 65'd70, 4'd0, 65'd71, 10'h07);
    wait_drain(10);

    // Async reset mid-stream clears outputs without waiting for an edge.
    $display("[TB] async reset");
    issue_ready = 1'b0;
    apply_stimulus(4'd1, 4'd0, 65'd5, 4'd0, 65'd6, 10'h3C);
    apply_stimulus(4'd2, 4'd0, 65'd5, 4'd0, 65'd6, 10'h3C);
    check_output("pre_reset_valid", 128'(issue_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_valid", 128'(issue_valid), 128'(0));
    check_output("areset_dest", 128'(issue_dest), 128'(0));
    check_output("areset_val1", 128'(issue_v1), 128'(0));
    check_output("areset_val2", 128'(issue_v2), 128'(0));
    check_output("areset_cmd", 128'(issue_cmd), 128'(0));
    tick();
    #2;
    rst_n = 1'b1;
    issue_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check_output("post_reset_empty", 128'(issue_valid), 128'(0));
    push_exp(4'd8, 10'h08, 64'd80, 64'd81);
    apply_stimulus(4'd8, 4'd0, 65'd80, 4'd0, 65'd81, 10'h08);
    wait_drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
